// File: rtl/memory_bus_arbiter_if.sv
// rtl/memory_bus_arbiter_if.sv - request, completion and shared-bus signals of the memory bus arbiter
interface memory_bus_arbiter_if;
  // Fetch port
  logic        i_req;
  logic [31:0] i_address;
  logic        i_done;
  logic [31:0] i_read_data;
  // Data port
  logic        d_req;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_write_data;
  logic [3:0]  d_byte_enable;
  logic        d_done;
  logic [31:0] d_read_data;
  // Shared memory bus
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        mem_done;
  logic [31:0] mem_read_data;

  // Arbiter side: serves the core's requests and drives the memory bus
  modport slave (
    input  i_req, i_address, d_req, d_write, d_address, d_write_data, d_byte_enable,
    input  mem_done, mem_read_data,
    output i_done, i_read_data, d_done, d_read_data,
    output mem_address, mem_write_data, mem_byte_enable, mem_read_enable, mem_write_enable
  );

  // Environment side: the core's two ports plus the memory
  modport master (
    output i_req, i_address, d_req, d_write, d_address, d_write_data, d_byte_enable,
    output mem_done, mem_read_data,
    input  i_done, i_read_data, d_done, d_read_data,
    input  mem_address, mem_write_data, mem_byte_enable, mem_read_enable, mem_write_enable
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - fetch/data arbiter for one single-port memory bus with bounded data streak
module memory_bus_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input logic                  clock,
  input logic                  reset,
  memory_bus_arbiter_if.slave  bus
);

  localparam logic [7:0] STREAK_MAX = 8'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] streak, streak_next;

  // State and streak registers; reset abandons any in-flight transaction
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      streak <= 8'd0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
    end
  end

  // Arbitration, bus steering and completion routing
  always_comb begin
    state_next           = state;
    streak_next          = streak;
    bus.mem_address      = 32'd0;
    bus.mem_write_data   = 32'd0;
    bus.mem_byte_enable  = 4'd0;
    bus.mem_read_enable  = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.i_done           = 1'b0;
    bus.i_read_data      = 32'd0;
    bus.d_done           = 1'b0;
    bus.d_read_data      = 32'd0;
    case (state)
      IDLE: begin
        // Data has priority unless fetch has waited through a full streak
        if (bus.d_req && !(bus.i_req && streak == STREAK_MAX)) begin
          state_next = GRANT_D;
          if (bus.i_req)
            streak_next = (streak == STREAK_MAX) ? STREAK_MAX : streak + 8'd1;
          else
            streak_next = 8'd0;
        end else if (bus.i_req) begin
          state_next  = GRANT_I;
          streak_next = 8'd0;
        end
      end
      GRANT_D: begin
        bus.mem_address      = bus.d_address;
        bus.mem_write_data   = bus.d_write_data;
        bus.mem_byte_enable  = bus.d_write ? bus.d_byte_enable : 4'b1111;
        bus.mem_read_enable  = !bus.d_write;
        bus.mem_write_enable = bus.d_write;
        if (bus.mem_done) begin
          bus.d_done      = 1'b1;
          bus.d_read_data = bus.mem_read_data;
          state_next      = IDLE;
        end
      end
      GRANT_I: begin
        bus.mem_address     = bus.i_address;
        bus.mem_byte_enable = 4'b1111;
        bus.mem_read_enable = 1'b1;
        if (bus.mem_done) begin
          bus.i_done      = 1'b1;
          bus.i_read_data = bus.mem_read_data;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb/tb_memory_bus_arbiter.sv - vector table, starvation sequence and random model check of memory_bus_arbiter
module tb_memory_bus_arbiter;

  localparam int MAX = 4;
  localparam logic [31:0] IA  = 32'h0000_0100;
  localparam logic [31:0] DA  = 32'h0000_2004;
  localparam logic [31:0] DW  = 32'hDEAD_BEEF;
  localparam logic [3:0]  DBE = 4'b0011;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  memory_bus_arbiter_if bus ();

  memory_bus_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         rst_n;
    logic         ireq;
    logic         dreq;
    logic         dwr;
    logic         mdone;
    logic [31:0]  mrdata;
    logic [135:0] exp;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [135:0] pk(logic [31:0] a, logic [31:0] wd, logic [3:0] be,
                                      logic ren, logic wen, logic idn, logic [31:0] ird,
                                      logic ddn, logic [31:0] drd);
    return {a, wd, be, ren, wen, idn, ird, ddn, drd};
  endfunction

  function automatic logic [135:0] outs();
    return {bus.mem_address, bus.mem_write_data, bus.mem_byte_enable, bus.mem_read_enable,
            bus.mem_write_enable, bus.i_done, bus.i_read_data, bus.d_done, bus.d_read_data};
  endfunction

  function automatic vec_t mk(logic r, logic i, logic d, logic w, logic md, logic [31:0] rd,
                              logic [135:0] e);
    vec_t v;
    v.rst_n = r; v.ireq = i; v.dreq = d; v.dwr = w; v.mdone = md; v.mrdata = rd; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_req = 0; bus.i_address = 0; bus.d_req = 0; bus.d_write = 0; bus.d_address = 0;
    bus.d_write_data = 0; bus.d_byte_enable = 0; bus.mem_done = 0; bus.mem_read_data = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    clear_inputs();
    reset = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #3;
    check("reset_outputs", outs(), '0);
    #1 reset = 1'b1;
  endtask

  // Random-phase model: who owns the bus and how many data grants ran while fetch waited
  int          owner;        // 0 none, 1 data, 2 fetch
  int          run;
  logic        i_pend, d_pend, i_seen, d_seen;
  logic [135:0] e;
  string       order;
  string       want_order;
  int          grants;

  initial begin
    clear_inputs();
    do_reset();

    // Cycle-by-cycle vectors: fetch, store, collision, stray mem_done, reset mid-grant
    tbl[0]  = mk(1,0,0,0,0,32'h0, '0);
    tbl[1]  = mk(1,1,0,0,0,32'h0, '0);
    tbl[2]  = mk(1,1,0,0,1,32'h13, pk(IA,0,4'hF,1,0,1,32'h13,0,0));
    tbl[3]  = mk(1,0,0,0,0,32'h0, '0);
    tbl[4]  = mk(1,0,1,1,0,32'h0, '0);
    tbl[5]  = mk(1,0,1,1,0,32'h0, pk(DA,DW,DBE,0,1,0,0,0,0));
    tbl[6]  = mk(1,0,1,1,1,32'h55, pk(DA,DW,DBE,0,1,0,0,1,32'h55));
    tbl[7]  = mk(1,0,0,0,0,32'h0, '0);
    tbl[8]  = mk(1,1,1,0,0,32'h0, '0);
    tbl[9]  = mk(1,1,1,0,1,32'hA5A5A5A5, pk(DA,DW,4'hF,1,0,0,0,1,32'hA5A5A5A5));
    tbl[10] = mk(1,1,0,0,0,32'h0, '0);
    tbl[11] = mk(1,1,0,0,1,32'h77, pk(IA,0,4'hF,1,0,1,32'h77,0,0));
    tbl[12] = mk(1,0,0,0,0,32'h0, '0);
    tbl[13] = mk(1,0,0,0,1,32'hFFFFFFFF, '0);
    tbl[14] = mk(1,0,0,0,0,32'h0, '0);
    tbl[15] = mk(1,0,1,0,0,32'h0, '0);
    tbl[16] = mk(0,0,1,0,0,32'h0, pk(DA,DW,4'hF,1,0,0,0,0,0));
    tbl[17] = mk(1,0,1,0,0,32'h0, '0);
    tbl[18] = mk(1,0,1,0,1,32'h1234, pk(DA,DW,4'hF,1,0,0,0,1,32'h1234));
    tbl[19] = mk(1,0,0,0,0,32'h0, '0);

    bus.i_address = IA; bus.d_address = DA; bus.d_write_data = DW; bus.d_byte_enable = DBE;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      reset = tbl[k].rst_n; bus.i_req = tbl[k].ireq; bus.d_req = tbl[k].dreq;
      bus.d_write = tbl[k].dwr; bus.mem_done = tbl[k].mdone; bus.mem_read_data = tbl[k].mrdata;
      #3;
      check($sformatf("vec%0d", k), outs(), tbl[k].exp);
    end

    // Starvation bound: both ports held high, memory completes in the first grant cycle
    do_reset();
    want_order = "DDDDIDDDDI";
    order = "";
    grants = 0;
    bus.i_address = IA; bus.d_address = DA; bus.d_write = 0; bus.d_write_data = DW;
    bus.i_req = 1; bus.d_req = 1;
    for (int c = 0; c < 100 && grants < 10; c++) begin
      @(posedge clock); #1;
      bus.mem_done = bus.mem_read_enable | bus.mem_write_enable;
      bus.mem_read_data = 32'(c);
      #3;
      if (bus.mem_read_enable) begin
        order = {order, (bus.mem_address == DA) ? "D" : "I"};
        grants++;
      end
    end
    checks++;
    if (order != want_order) begin
      errors++;
      $display("FAIL starvation_order got=%s want=%s", order, want_order);
    end

    // Random protocol-legal traffic against the transaction-level model
    do_reset();
    owner = 0; run = 0; i_pend = 0; d_pend = 0; i_seen = 0; d_seen = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clock); #1;
      if (i_seen) i_pend = 0;
      if (d_seen) d_pend = 0;
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1;
        bus.i_address = $urandom() & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 2) == 1) begin
        d_pend = 1;
        bus.d_address = $urandom();
        bus.d_write = 1'($urandom_range(0, 1));
        bus.d_write_data = $urandom();
        bus.d_byte_enable = 4'($urandom_range(0, 15));
      end
      bus.i_req = i_pend;
      bus.d_req = d_pend;
      if (bus.mem_read_enable | bus.mem_write_enable)
        bus.mem_done = 1'($urandom_range(0, 1));
      else
        bus.mem_done = ($urandom_range(0, 7) == 0);
      bus.mem_read_data = $urandom();
      #3;
      if (owner == 1)
        e = pk(bus.d_address, bus.d_write_data, bus.d_write ? bus.d_byte_enable : 4'hF,
               !bus.d_write, bus.d_write, 0, 0, bus.mem_done,
               bus.mem_done ? bus.mem_read_data : 32'h0);
      else if (owner == 2)
        e = pk(bus.i_address, 0, 4'hF, 1, 0, bus.mem_done,
               bus.mem_done ? bus.mem_read_data : 32'h0, 0, 0);
      else
        e = '0;
      check($sformatf("rand%0d", c), outs(), e);
      i_seen = bus.i_done;
      d_seen = bus.d_done;
      if (owner != 0) begin
        if (bus.mem_done) owner = 0;
      end else if (d_pend && !(i_pend && run >= MAX)) begin
        owner = 1;
        run = i_pend ? ((run + 1 > MAX) ? MAX : run + 1) : 0;
      end else if (i_pend) begin
        owner = 2;
        run = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
